binary_bbox_overlay: RTL and testbench
======================================

Name: binary_bbox_overlay

Overview:
- Sits directly downstream of the RGB/gray/binary conversion stage.
- Consumes that stage's video output (24-bit pixel, binary threshold flag, x/y, hs/vs/de).
- Accumulates a per-frame bounding box of foreground pixels (flag = 1) inside a fixed region of interest (ROI).
- On the next frame, draws that box as a 1-pixel coloured rectangle over the passing video; also exports the box coordinates.

Parameters:
- WIN_X0, 70: ROI left bound, exclusive.
- WIN_X1, 430: ROI right bound, exclusive.
- WIN_Y0, 80: ROI top bound, exclusive.
- WIN_Y1, 190: ROI bottom bound, exclusive.
- MIN_PIX, 16: minimum foreground pixel count for a box to be valid.
- BOX_COLOR, 24'hFF0000: rectangle colour.
- VS_ACTIVE, 1'b1: active level of i_vs.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset, asynchronous, active-low
- i_hs  input  1  horizontal sync
- i_vs  input  1  vertical sync
- i_de  input  1  data enable
- i_x  input  12  pixel x position
- i_y  input  12  pixel y position
- i_data  input  24  RGB888 pixel
- i_flag  input  1  binary threshold flag for this pixel
- o_hs  output  1  i_hs delayed by 1 clk
- o_vs  output  1  i_vs delayed by 1 clk
- o_de  output  1  i_de delayed by 1 clk
- o_data  output  24  pixel with box overlay, 1 clk latency
- box_valid  output  1  latched box from the last completed frame is valid
- box_x0, box_x1, box_y0, box_y1  output  12 each  latched box min/max coordinates

Behaviour:
- Reset (async, rst_n low):
  - o_hs/o_vs/o_de = 0; o_data = 0; box_valid = 0; box_* = 0.
  - Accumulators: min_x = min_y = 12'hFFF, max_x = max_y = 0, count = 0.
  - State = S_WAIT.
- Frame edge:
  - vs_d is i_vs registered.
  - frame_edge = (i_vs == VS_ACTIVE) && (vs_d != VS_ACTIVE), i.e. single-cycle entry into vsync.
- Qualified pixel:
  - i_de && i_flag && i_x > WIN_X0 && i_x < WIN_X1 && i_y > WIN_Y0 && i_y < WIN_Y1.
  - ROI boundaries are exclusive.
- Accumulation (qualified pixel, no frame_edge, state S_ACC):
  - min_x = min(min_x, i_x), likewise max_x, min_y, max_y.
  - count increments by 1, 20-bit, saturating at 20'hFFFFF (no wrap).
- State machine:
  - S_WAIT: accumulators held at init values, pixels ignored. On frame_edge go to S_ACC; no latch. A partial frame after reset is never reported.
  - S_ACC, on frame_edge:
    - If count >= MIN_PIX: box_* <= min/max, box_valid <= 1.
    - Else: box_valid <= 0 and box_* hold previous values.
    - Accumulators re-init in the same cycle; stay in S_ACC.
- Simultaneous events:
  - A qualified pixel in the frame_edge cycle is discarded; re-init wins.
- Overlay (registered, 1 clk):
  - on_box = box_valid && i_de && one of:
    - (i_x == box_x0 or i_x == box_x1) with box_y0 <= i_y <= box_y1
    - (i_y == box_y0 or i_y == box_y1) with box_x0 <= i_x <= box_x1
  - o_data <= on_box ? BOX_COLOR : i_data.
  - o_hs/o_vs/o_de <= i_hs/i_vs/i_de.
  - o_data is passed through even when i_de = 0.
- Box latency: the box drawn during frame N is the one accumulated over frame N-1. box_* change only on frame_edge (during vsync), so there is no mid-frame tearing.
- Degenerate box: a single qualified pixel with MIN_PIX ≤ 1 gives box_x0 = box_x1; drawn as a vertical/horizontal segment or a single dot.
- Reset mid-frame: everything returns to the reset values above; the next frame_edge only arms the block (S_WAIT → S_ACC).

Decomposition:
- Shared package:
  - COORD_W = 12, COORD_MAX = 12'hFFF, CNT_W = 20.
  - State enum: S_WAIT, S_ACC.
- Sub-module bbox_accum: holds the min/max/count accumulators, the state machine and the latch logic.
  - Inputs: clk, rst_n, frame_edge, pix_valid, x, y.
  - Outputs: box_valid, box_* .
- Top binary_bbox_overlay:
  - vs edge detect, ROI qualification, overlay compare, 1-cycle video delay register.

Test Plan:
- Reset, then frame 1 with 20 qualified pixels at (100..119, 120), then frame_edge → no latch (S_WAIT arming), box_valid = 0. Repeat on frame 2, then frame_edge → box_valid = 1, box = (100, 120)-(119, 120).
- In S_ACC, frame with 4 corner pixels (71,81), (429,81), (71,189), (429,189) and MIN_PIX = 4 → box (71,81)-(429,189), box_valid = 1. Pixels at x = 70 or y = 190 → ignored.
- Latched box (200,100)-(300,150), box_valid = 1, i_data = 24'h123456:
  - Pixel (200,125) → o_data = 24'hFF0000 one clk later.
  - Pixel (250,125) → o_data = 24'h123456.
  - Pixel (250,151) → o_data = 24'h123456.
- Frame with only 15 qualified pixels (MIN_PIX = 16) → box_valid drops to 0, box_* unchanged, no rectangle drawn next frame.
- Qualified pixel (150,150) asserted in the frame_edge cycle → not included in either frame's box. hs/vs/de are observed delayed by exactly 1 clk throughout.
- rst_n pulsed low mid-frame after a valid box → all outputs 0 immediately; first subsequent frame_edge does not latch; second frame_edge latches normally.

Source files
------------

// File: rtl/binary_bbox_overlay_pkg.sv
// Shared types and constants for the binary bounding-box overlay block.
// Coordinate/counter widths and the accumulator state encoding live here.
package binary_bbox_overlay_pkg;

    localparam int             COORD_W   = 12;
    localparam logic [11:0]    COORD_MAX = 12'hFFF;
    localparam int             CNT_W     = 20;
    localparam logic [19:0]    CNT_MAX   = 20'hFFFFF;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    function automatic logic [COORD_W-1:0] min_coord(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [COORD_W-1:0] max_coord(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/binary_bbox_overlay_accum.sv
// Per-frame min/max/count accumulation of foreground pixels and the
// frame-boundary latch that publishes the previous frame's bounding box.
module bbox_accum
    import binary_bbox_overlay_pkg::*;
#(
    parameter int MIN_PIX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_edge,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               box_valid,
    output logic [COORD_W-1:0] box_x0,
    output logic [COORD_W-1:0] box_x1,
    output logic [COORD_W-1:0] box_y0,
    output logic [COORD_W-1:0] box_y1
);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               box_valid_q, box_valid_d;
    logic [COORD_W-1:0] box_x0_q, box_x0_d, box_x1_q, box_x1_d;
    logic [COORD_W-1:0] box_y0_q, box_y0_d, box_y1_q, box_y1_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            min_x_q     <= COORD_MAX;
            max_x_q     <= '0;
            min_y_q     <= COORD_MAX;
            max_y_q     <= '0;
            count_q     <= '0;
            box_valid_q <= 1'b0;
            box_x0_q    <= '0;
            box_x1_q    <= '0;
            box_y0_q    <= '0;
            box_y1_q    <= '0;
        end else begin
            state_q     <= state_d;
            min_x_q     <= min_x_d;
            max_x_q     <= max_x_d;
            min_y_q     <= min_y_d;
            max_y_q     <= max_y_d;
            count_q     <= count_d;
            box_valid_q <= box_valid_d;
            box_x0_q    <= box_x0_d;
            box_x1_q    <= box_x1_d;
            box_y0_q    <= box_y0_d;
            box_y1_q    <= box_y1_d;
        end
    end

    // A frame edge always re-initialises the accumulators, so a pixel arriving
    // in that same cycle is deliberately dropped.
    always_comb begin
        state_d     = state_q;
        min_x_d     = min_x_q;
        max_x_d     = max_x_q;
        min_y_d     = min_y_q;
        max_y_d     = max_y_q;
        count_d     = count_q;
        box_valid_d = box_valid_q;
        box_x0_d    = box_x0_q;
        box_x1_d    = box_x1_q;
        box_y0_d    = box_y0_q;
        box_y1_d    = box_y1_q;

        case (state_q)
            S_WAIT: begin
                min_x_d = COORD_MAX;
                max_x_d = '0;
                min_y_d = COORD_MAX;
                max_y_d = '0;
                count_d = '0;
                if (frame_edge) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (frame_edge) begin
                    if (count_q >= CNT_W'(MIN_PIX)) begin
                        box_valid_d = 1'b1;
                        box_x0_d    = min_x_q;
                        box_x1_d    = max_x_q;
                        box_y0_d    = min_y_q;
                        box_y1_d    = max_y_q;
                    end else begin
                        box_valid_d = 1'b0;
                    end
                    min_x_d = COORD_MAX;
                    max_x_d = '0;
                    min_y_d = COORD_MAX;
                    max_y_d = '0;
                    count_d = '0;
                end else if (pix_valid) begin
                    min_x_d = min_coord(min_x_q, x);
                    max_x_d = max_coord(max_x_q, x);
                    min_y_d = min_coord(min_y_q, y);
                    max_y_d = max_coord(max_y_q, y);
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign box_valid = box_valid_q;
    assign box_x0    = box_x0_q;
    assign box_x1    = box_x1_q;
    assign box_y0    = box_y0_q;
    assign box_y1    = box_y1_q;

endmodule

// File: rtl/binary_bbox_overlay.sv
// Bounding-box overlay: finds foreground pixels inside a fixed ROI, and draws
// the previous frame's box as a 1-pixel rectangle on the delayed video.
module binary_bbox_overlay
    import binary_bbox_overlay_pkg::*;
#(
    parameter int          WIN_X0    = 70,
    parameter int          WIN_X1    = 430,
    parameter int          WIN_Y0    = 80,
    parameter int          WIN_Y1    = 190,
    parameter int          MIN_PIX   = 16,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000,
    parameter logic        VS_ACTIVE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_de,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [23:0]        i_data,
    input  logic               i_flag,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic [23:0]        o_data,
    output logic               box_valid,
    output logic [COORD_W-1:0] box_x0,
    output logic [COORD_W-1:0] box_x1,
    output logic [COORD_W-1:0] box_y0,
    output logic [COORD_W-1:0] box_y1
);

    logic        vs_q, vs_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;
    logic        de_out_q, de_out_d;
    logic [23:0] data_out_q, data_out_d;
    logic        frame_edge;
    logic        pix_valid;
    logic        on_x_edge, on_y_edge, in_x_span, in_y_span;
    logic        on_box;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            vs_q       <= vs_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
            de_out_q   <= de_out_d;
            data_out_q <= data_out_d;
        end
    end

    // ROI bounds are exclusive on all four sides.
    always_comb begin
        frame_edge = (i_vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);
        pix_valid  = i_de && i_flag
                     && (i_x > COORD_W'(WIN_X0)) && (i_x < COORD_W'(WIN_X1))
                     && (i_y > COORD_W'(WIN_Y0)) && (i_y < COORD_W'(WIN_Y1));
    end

    bbox_accum #(
        .MIN_PIX (MIN_PIX)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_edge (frame_edge),
        .pix_valid  (pix_valid),
        .x          (i_x),
        .y          (i_y),
        .box_valid  (box_valid),
        .box_x0     (box_x0),
        .box_x1     (box_x1),
        .box_y0     (box_y0),
        .box_y1     (box_y1)
    );

    // Video is passed through even outside the active area; only the colour changes on the box outline.
    always_comb begin
        in_x_span  = (i_x >= box_x0) && (i_x <= box_x1);
        in_y_span  = (i_y >= box_y0) && (i_y <= box_y1);
        on_x_edge  = (i_x == box_x0) || (i_x == box_x1);
        on_y_edge  = (i_y == box_y0) || (i_y == box_y1);
        on_box     = box_valid && i_de
                     && ((on_x_edge && in_y_span) || (on_y_edge && in_x_span));
        vs_d       = i_vs;
        hs_out_d   = i_hs;
        vs_out_d   = i_vs;
        de_out_d   = i_de;
        data_out_d = on_box ? BOX_COLOR : i_data;
    end

    assign o_hs   = hs_out_q;
    assign o_vs   = vs_out_q;
    assign o_de   = de_out_q;
    assign o_data = data_out_q;

endmodule

// File: tb/tb_binary_bbox_overlay.sv
// Directed testbench for binary_bbox_overlay: hand-computed boxes, overlay
// colours, sync delays and reset behaviour.
module tb_binary_bbox_overlay;

    logic        clk;
    logic        rst_n;
    logic        i_hs, i_vs, i_de, i_flag;
    logic [11:0] i_x, i_y;
    logic [23:0] i_data;
    logic        o_hs, o_vs, o_de;
    logic [23:0] o_data;
    logic        box_valid;
    logic [11:0] box_x0, box_x1, box_y0, box_y1;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] BG  = 24'h123456;

    binary_bbox_overlay dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_hs      (i_hs),
        .i_vs      (i_vs),
        .i_de      (i_de),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_data    (i_data),
        .i_flag    (i_flag),
        .o_hs      (o_hs),
        .o_vs      (o_vs),
        .o_de      (o_de),
        .o_data    (o_data),
        .box_valid (box_valid),
        .box_x0    (box_x0),
        .box_x1    (box_x1),
        .box_y0    (box_y0),
        .box_y1    (box_y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return just after the
    // rising edge that registers them.
    task automatic applyStimulus(input logic hs, input logic vs, input logic de,
                                 input logic [11:0] x, input logic [11:0] y,
                                 input logic flag, input logic [23:0] data);
        @(negedge clk);
        i_hs   = hs;
        i_vs   = vs;
        i_de   = de;
        i_x    = x;
        i_y    = y;
        i_flag = flag;
        i_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic sendPixel(input logic [11:0] x, input logic [11:0] y,
                             input logic flag, input logic [23:0] data);
        applyStimulus(1'b0, 1'b0, 1'b1, x, y, flag, data);
        checkOutput("o_de_pixel", {31'd0, o_de}, 32'd1);
    endtask

    task automatic hBlank();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 24'd0);
        checkOutput("o_hs_blank", {31'd0, o_hs}, 32'd1);
        checkOutput("o_de_blank", {31'd0, o_de}, 32'd0);
    endtask

    // Vsync for three cycles; the first cycle optionally carries a qualified pixel.
    task automatic doVsync(input logic edgeDe, input logic [11:0] edgeX, input logic [11:0] edgeY);
        applyStimulus(1'b0, 1'b1, edgeDe, edgeX, edgeY, edgeDe, 24'd0);
        checkOutput("o_vs_delay", {31'd0, o_vs}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 24'd0);
        checkOutput("o_vs_fall", {31'd0, o_vs}, 32'd0);
    endtask

    task automatic checkBox(input string tag, input logic valid,
                            input logic [11:0] x0, input logic [11:0] x1,
                            input logic [11:0] y0, input logic [11:0] y1);
        checkOutput({tag, "_valid"}, {31'd0, box_valid}, {31'd0, valid});
        checkOutput({tag, "_x0"}, {20'd0, box_x0}, {20'd0, x0});
        checkOutput({tag, "_x1"}, {20'd0, box_x1}, {20'd0, x1});
        checkOutput({tag, "_y0"}, {20'd0, box_y0}, {20'd0, y0});
        checkOutput({tag, "_y1"}, {20'd0, box_y1}, {20'd0, y1});
    endtask

    // Drive a row of flagged pixels starting at (x, y) moving right.
    task automatic sendRow(input logic [11:0] x, input logic [11:0] y, input int n);
        for (int i = 0; i < n; i++) begin
            sendPixel(x + 12'(i), y, 1'b1, BG);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        i_hs   = 1'b0;
        i_vs   = 1'b0;
        i_de   = 1'b0;
        i_x    = '0;
        i_y    = '0;
        i_flag = 1'b0;
        i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_o_hs", {31'd0, o_hs}, 32'd0);
        checkOutput("rst_o_vs", {31'd0, o_vs}, 32'd0);
        checkOutput("rst_o_de", {31'd0, o_de}, 32'd0);
        checkOutput("rst_o_data", {8'd0, o_data}, 32'd0);
        checkBox("rst_box", 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1 is partial after reset: its edge only arms accumulation.
        sendRow(12'd100, 12'd120, 20);
        hBlank();
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("arm_box", 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);

        sendRow(12'd100, 12'd120, 20);
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("row_box", 1'b1, 12'd100, 12'd119, 12'd120, 12'd120);

        // Corners just inside the ROI, pixels on/beyond the bounds, overlay of row box.
        sendPixel(12'd110, 12'd120, 1'b0, BG);
        checkOutput("ovl_row_on", {8'd0, o_data}, {8'd0, RED});
        sendPixel(12'd110, 12'd121, 1'b0, BG);
        checkOutput("ovl_row_off", {8'd0, o_data}, {8'd0, BG});
        sendPixel(12'd71, 12'd81, 1'b1, BG);
        sendPixel(12'd429, 12'd81, 1'b1, BG);
        sendPixel(12'd71, 12'd189, 1'b1, BG);
        sendPixel(12'd429, 12'd189, 1'b1, BG);
        sendPixel(12'd70, 12'd100, 1'b1, BG);
        sendPixel(12'd430, 12'd100, 1'b1, BG);
        sendPixel(12'd300, 12'd80, 1'b1, BG);
        sendPixel(12'd300, 12'd190, 1'b1, BG);
        sendRow(12'd200, 12'd130, 12);
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("corner_box", 1'b1, 12'd71, 12'd429, 12'd81, 12'd189);

        // Exactly MIN_PIX qualified pixels forming (200,100)-(300,150).
        sendPixel(12'd71, 12'd100, 1'b0, BG);
        checkOutput("ovl_corner_on", {8'd0, o_data}, {8'd0, RED});
        sendPixel(12'd72, 12'd100, 1'b0, BG);
        checkOutput("ovl_corner_off", {8'd0, o_data}, {8'd0, BG});
        sendPixel(12'd200, 12'd100, 1'b1, BG);
        sendPixel(12'd300, 12'd150, 1'b1, BG);
        sendRow(12'd210, 12'd120, 14);
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("min_pix_box", 1'b1, 12'd200, 12'd300, 12'd100, 12'd150);

        // Overlay probes on the latched box, then only 15 qualified pixels.
        sendPixel(12'd200, 12'd125, 1'b0, BG);
        checkOutput("ovl_left_edge", {8'd0, o_data}, {8'd0, RED});
        sendPixel(12'd250, 12'd125, 1'b0, BG);
        checkOutput("ovl_inside", {8'd0, o_data}, {8'd0, BG});
        sendPixel(12'd250, 12'd151, 1'b0, BG);
        checkOutput("ovl_below", {8'd0, o_data}, {8'd0, BG});
        sendPixel(12'd300, 12'd150, 1'b0, BG);
        checkOutput("ovl_corner", {8'd0, o_data}, {8'd0, RED});
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd200, 12'd125, 1'b0, BG);
        checkOutput("ovl_no_de", {8'd0, o_data}, {8'd0, BG});
        sendRow(12'd150, 12'd160, 15);
        doVsync(1'b1, 12'd150, 12'd150);
        checkBox("short_box", 1'b0, 12'd200, 12'd300, 12'd100, 12'd150);

        // No rectangle while invalid; the edge-cycle pixel must not show up here.
        sendPixel(12'd200, 12'd125, 1'b0, BG);
        checkOutput("ovl_invalid", {8'd0, o_data}, {8'd0, BG});
        sendRow(12'd300, 12'd100, 16);
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("edge_pix_box", 1'b1, 12'd300, 12'd315, 12'd100, 12'd100);

        // Asynchronous reset in the middle of a frame.
        sendRow(12'd120, 12'd110, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_o_de", {31'd0, o_de}, 32'd0);
        checkOutput("mid_rst_o_data", {8'd0, o_data}, 32'd0);
        checkBox("mid_rst_box", 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sendRow(12'd120, 12'd110, 16);
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("post_rst_arm", 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
        sendRow(12'd130, 12'd140, 16);
        doVsync(1'b0, 12'd0, 12'd0);
        checkBox("post_rst_box", 1'b1, 12'd130, 12'd145, 12'd140, 12'd140);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
